// File: rtl/vec_move_engine_pkg.sv
// Shared encodings and default widths for the vector move engine.
// Mode values match the 2-bit mode port; state values are used only inside the engine.
package vec_move_engine_pkg;

    localparam int VME_ADDR_W = 11;
    localparam int VME_DATA_W = 32;
    localparam int VME_LEN_W  = 16;
    localparam int VME_SH_W   = 5;

    typedef enum logic [1:0] {
        MODE_COPY = 2'd0,
        MODE_SET  = 2'd1,
        MODE_SHR  = 2'd2,
        MODE_RSVD = 2'd3
    } vme_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } vme_state_e;

    // The reserved encoding behaves as a fill with zero.
    function automatic logic isFillMode(input vme_mode_e m);
        return (m == MODE_SET) || (m == MODE_RSVD);
    endfunction

endpackage

// File: rtl/vec_move_engine_if.sv
// Control handshake and scratch-memory port bundle of the vector move engine.
// The engine connects through the slave modport; the sequencer/memory side uses master.
interface vec_move_engine_if
    import vec_move_engine_pkg::*;
#(
    parameter int ADDR_W = VME_ADDR_W,
    parameter int DATA_W = VME_DATA_W,
    parameter int LEN_W  = VME_LEN_W,
    parameter int SH_W   = VME_SH_W
);
    logic              start;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] xAddr;
    logic [ADDR_W-1:0] yAddr;
    logic [LEN_W-1:0]  L;
    logic [DATA_W-1:0] setVal;
    logic [SH_W-1:0]   shift;
    logic [DATA_W-1:0] memIn;
    logic [ADDR_W-1:0] memReadAddr;
    logic [ADDR_W-1:0] memWriteAddr;
    logic [DATA_W-1:0] memOut;
    logic              memWriteEn;
    logic              busy;
    logic              done;

    modport slave (
        input  start, mode, xAddr, yAddr, L, setVal, shift, memIn,
        output memReadAddr, memWriteAddr, memOut, memWriteEn, busy, done
    );

    modport master (
        output start, mode, xAddr, yAddr, L, setVal, shift, memIn,
        input  memReadAddr, memWriteAddr, memOut, memWriteEn, busy, done
    );
endinterface

// File: rtl/vec_move_engine_addr_gen.sv
// Element sequencer: remaining-count, ASC/DESC stepping, wrapped source/destination
// addresses for the element addressed this cycle, and the last-element flag.
module vme_addr_gen #(
    parameter int ADDR_W = 11,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic              fillMode,
    input  logic [ADDR_W-1:0] xBase,
    input  logic [ADDR_W-1:0] yBase,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] rdAddr,
    output logic [ADDR_W-1:0] wrAddr,
    output logic [ADDR_W-1:0] wrAddrNext,
    output logic              last
);

    localparam int CMP_W = (LEN_W > ADDR_W + 1) ? LEN_W : ADDR_W + 1;

    logic [ADDR_W-1:0] rdAddrR;
    logic [ADDR_W-1:0] wrAddrR;
    logic [LEN_W-1:0]  cntR;
    logic              descR;
    logic              rdActiveR;

    logic [ADDR_W:0]   gapS;
    logic [CMP_W-1:0]  gapWideS;
    logic [CMP_W-1:0]  lenWideS;
    logic              descS;
    logic [ADDR_W-1:0] firstOffS;
    logic [ADDR_W-1:0] rdAddrNextS;

    // Direction decision: copy top-down only when the destination starts inside the source.
    always_comb begin
        gapS      = {1'b0, yBase} - {1'b0, xBase};
        gapWideS  = CMP_W'(gapS);
        lenWideS  = CMP_W'(len);
        descS     = !fillMode && (yBase > xBase) && (gapWideS < lenWideS);
        firstOffS = descS ? ADDR_W'(len - LEN_W'(1'b1)) : {ADDR_W{1'b0}};
    end

    // Neighbouring element addresses, wrapping modulo 2^ADDR_W.
    always_comb begin
        if (descR) begin
            rdAddrNextS = rdAddrR - ADDR_W'(1'b1);
            wrAddrNext  = wrAddrR - ADDR_W'(1'b1);
        end else begin
            rdAddrNextS = rdAddrR + ADDR_W'(1'b1);
            wrAddrNext  = wrAddrR + ADDR_W'(1'b1);
        end
    end

    // Counter and address registers; the read address is frozen during fills.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdAddrR   <= {ADDR_W{1'b0}};
            wrAddrR   <= {ADDR_W{1'b0}};
            cntR      <= {LEN_W{1'b0}};
            descR     <= 1'b0;
            rdActiveR <= 1'b0;
        end else if (load) begin
            if (!fillMode) begin
                rdAddrR <= xBase + firstOffS;
            end else begin
                rdAddrR <= rdAddrR;
            end
            wrAddrR   <= yBase + firstOffS;
            cntR      <= len - LEN_W'(1'b1);
            descR     <= descS;
            rdActiveR <= !fillMode;
        end else if (step) begin
            if (rdActiveR) begin
                rdAddrR <= rdAddrNextS;
            end else begin
                rdAddrR <= rdAddrR;
            end
            wrAddrR <= wrAddrNext;
            cntR    <= cntR - LEN_W'(1'b1);
        end else begin
            rdAddrR <= rdAddrR;
            wrAddrR <= wrAddrR;
            cntR    <= cntR;
        end
    end

    assign rdAddr = rdAddrR;
    assign wrAddr = wrAddrR;
    assign last   = (cntR == {LEN_W{1'b0}});

endmodule

// File: rtl/vec_move_engine.sv
// Vector move engine: COPY / SET / arithmetic SHR over L scratch-memory words,
// one word per cycle, overlap-safe, with a start/done handshake.
module vec_move_engine
    import vec_move_engine_pkg::*;
#(
    parameter int ADDR_W = VME_ADDR_W,
    parameter int DATA_W = VME_DATA_W,
    parameter int LEN_W  = VME_LEN_W,
    parameter int SH_W   = VME_SH_W
) (
    input logic             clk,
    input logic             reset,
    vec_move_engine_if.slave bus
);

    vme_state_e        stateR;
    vme_state_e        nextStateS;

    logic              fillModeR;
    logic              shrModeR;
    logic [SH_W-1:0]   shiftR;
    logic              memWriteEnR;
    logic [ADDR_W-1:0] memWriteAddrR;
    logic [DATA_W-1:0] memOutR;
    logic              wrFromMemR;
    logic              busyR;
    logic              doneR;

    vme_mode_e         modeInS;
    logic              acceptS;
    logic              lenZeroS;
    logic              fillInS;
    logic [DATA_W-1:0] fillValInS;
    logic [DATA_W-1:0] xformS;

    logic              agLoadS;
    logic              agStepS;
    logic              wrEnNextS;
    logic [ADDR_W-1:0] wrAddrNextS;
    logic              wrFromMemNextS;

    logic [ADDR_W-1:0] agRdAddrS;
    logic [ADDR_W-1:0] agWrAddrS;
    logic [ADDR_W-1:0] agWrNextS;
    logic              agLastS;

    vme_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .load       (agLoadS),
        .step       (agStepS),
        .fillMode   (fillInS),
        .xBase      (bus.xAddr),
        .yBase      (bus.yAddr),
        .len        (bus.L),
        .rdAddr     (agRdAddrS),
        .wrAddr     (agWrAddrS),
        .wrAddrNext (agWrNextS),
        .last       (agLastS)
    );

    // Request decode; inputs only matter in the cycle a start is accepted.
    always_comb begin
        modeInS    = vme_mode_e'(bus.mode);
        acceptS    = bus.start && ((stateR == ST_IDLE) || (stateR == ST_DONE));
        lenZeroS   = (bus.L == {LEN_W{1'b0}});
        fillInS    = isFillMode(modeInS);
        fillValInS = (modeInS == MODE_SET) ? bus.setVal : {DATA_W{1'b0}};
    end

    // Data transform applied to the word returning from memory.
    always_comb begin
        if (shrModeR) begin
            xformS = $signed(bus.memIn) >>> shiftR;
        end else begin
            xformS = bus.memIn;
        end
    end

    // Operation parameters captured on an accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            fillModeR <= 1'b0;
            shrModeR  <= 1'b0;
            shiftR    <= {SH_W{1'b0}};
        end else if (acceptS) begin
            fillModeR <= fillInS;
            shrModeR  <= (modeInS == MODE_SHR);
            shiftR    <= bus.shift;
        end else begin
            fillModeR <= fillModeR;
            shrModeR  <= shrModeR;
            shiftR    <= shiftR;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateR <= ST_IDLE;
        end else begin
            stateR <= nextStateS;
        end
    end

    // FSM next-state logic; fills skip DRAIN since nothing is in flight.
    always_comb begin
        nextStateS = stateR;
        case (stateR)
            ST_IDLE, ST_DONE: begin
                if (acceptS) begin
                    nextStateS = lenZeroS ? ST_DONE : ST_RUN;
                end else begin
                    nextStateS = stateR;
                end
            end
            ST_RUN: begin
                if (agLastS) begin
                    nextStateS = fillModeR ? ST_DONE : ST_DRAIN;
                end else begin
                    nextStateS = ST_RUN;
                end
            end
            ST_DRAIN: nextStateS = ST_DONE;
            default:  nextStateS = ST_IDLE;
        endcase
    end

    // FSM output logic: sequencer strobes and next values of the write port.
    always_comb begin
        agLoadS        = 1'b0;
        agStepS        = 1'b0;
        wrEnNextS      = 1'b0;
        wrAddrNextS    = memWriteAddrR;
        wrFromMemNextS = 1'b0;
        case (stateR)
            ST_IDLE, ST_DONE: begin
                if (acceptS && !lenZeroS) begin
                    agLoadS = 1'b1;
                    if (fillInS) begin
                        wrEnNextS   = 1'b1;
                        wrAddrNextS = bus.yAddr;
                    end else begin
                        wrEnNextS   = 1'b0;
                        wrAddrNextS = memWriteAddrR;
                    end
                end else begin
                    agLoadS = 1'b0;
                end
            end
            ST_RUN: begin
                agStepS = !agLastS;
                if (fillModeR) begin
                    wrEnNextS   = !agLastS;
                    wrAddrNextS = agLastS ? memWriteAddrR : agWrNextS;
                end else begin
                    // Write for this cycle's read lands next cycle, when memIn returns.
                    wrEnNextS      = 1'b1;
                    wrAddrNextS    = agWrAddrS;
                    wrFromMemNextS = 1'b1;
                end
            end
            default: begin
                agLoadS = 1'b0;
            end
        endcase
    end

    // Registered output stage; memOutR keeps the last written word for idle hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            memWriteEnR   <= 1'b0;
            memWriteAddrR <= {ADDR_W{1'b0}};
            memOutR       <= {DATA_W{1'b0}};
            wrFromMemR    <= 1'b0;
            busyR         <= 1'b0;
            doneR         <= 1'b0;
        end else begin
            memWriteEnR   <= wrEnNextS;
            memWriteAddrR <= wrAddrNextS;
            wrFromMemR    <= wrFromMemNextS;
            busyR         <= (nextStateS == ST_RUN) || (nextStateS == ST_DRAIN);
            doneR         <= (nextStateS == ST_DONE);
            if (wrFromMemR) begin
                memOutR <= xformS;
            end else if (acceptS && !lenZeroS && fillInS) begin
                memOutR <= fillValInS;
            end else begin
                memOutR <= memOutR;
            end
        end
    end

    assign bus.memReadAddr  = agRdAddrS;
    assign bus.memWriteAddr = memWriteAddrR;
    assign bus.memOut       = wrFromMemR ? xformS : memOutR;
    assign bus.memWriteEn   = memWriteEnR;
    assign bus.busy         = busyR;
    assign bus.done         = doneR;

endmodule

// File: tb/tb_vec_move_engine.sv
// Scoreboard bench for vec_move_engine: directed operations push expected writes,
// a negedge monitor pops and compares every memWriteEn cycle against them.
module tb_vec_move_engine;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    vec_move_engine_if bus ();

    vec_move_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [10:0] addr;
        logic [31:0] data;
        logic        care;
    } exp_t;

    exp_t        expQ[$];
    int          nCompared   = 0;
    int          nMismatched = 0;
    int          writesSeen  = 0;

    logic [31:0] mem [0:2047];
    logic        tbWe;
    logic [10:0] tbWAddr;
    logic [31:0] tbWData;

    // Scratch memory: registered read (data one cycle after address), write on strobe.
    always @(posedge clk) begin
        bus.memIn <= mem[bus.memReadAddr];
        if (bus.memWriteEn === 1'b1) mem[bus.memWriteAddr] <= bus.memOut;
        if (tbWe) mem[tbWAddr] <= tbWData;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nCompared++;
        if (act !== req) begin
            nMismatched++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Write monitor: every strobed write must match the next queued expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.memWriteEn === 1'b1) begin
            writesSeen++;
            if (expQ.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("FAIL unexpected_write: actual addr=0x%03h data=0x%08h required=none",
                         bus.memWriteAddr, bus.memOut);
            end else begin
                e = expQ.pop_front();
                check("wr_addr", {21'd0, bus.memWriteAddr}, {21'd0, e.addr});
                if (e.care) check("wr_data", bus.memOut, e.data);
            end
        end
    end

    task automatic poke(input logic [10:0] a, input logic [31:0] d);
        tbWe = 1'b1; tbWAddr = a; tbWData = d;
        @(negedge clk);
        tbWe = 1'b0;
    endtask

    task automatic pushExp(input logic [10:0] a, input logic [31:0] d, input logic c);
        expQ.push_back('{addr: a, data: d, care: c});
    endtask

    // Issue one operation and follow it to done (or to a mid-run reset).
    task automatic runOp(input string tag, input logic [1:0] m, input logic [10:0] x,
                         input logic [10:0] y, input logic [15:0] len, input logic [31:0] sv,
                         input logic [4:0] sh, input int expDone, input int expWrites,
                         input int pokeCycle, input int resetCycle);
        int k;
        bit aborted;
        writesSeen = 0;
        bus.mode = m; bus.xAddr = x; bus.yAddr = y; bus.L = len;
        bus.setVal = sv; bus.shift = sh; bus.start = 1'b1;
        k = 0;
        aborted = 1'b0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                bus.start = 1'b0;
                if (len != 16'd0) begin
                    check({tag, "_busy_c1"}, {31'd0, bus.busy}, 32'd1);
                    check({tag, "_done_drop"}, {31'd0, bus.done}, 32'd0);
                end
            end
            if (pokeCycle != 0 && k == pokeCycle) begin
                bus.start = 1'b1; bus.mode = 2'd1; bus.yAddr = 11'd1500; bus.L = 16'd3;
            end
            if (pokeCycle != 0 && k == pokeCycle + 1) bus.start = 1'b0;
            if (resetCycle != 0 && k == resetCycle) reset = 1'b1;
            if (resetCycle != 0 && k == resetCycle + 1) begin
                check({tag, "_rst_we"},    {31'd0, bus.memWriteEn}, 32'd0);
                check({tag, "_rst_busy"},  {31'd0, bus.busy}, 32'd0);
                check({tag, "_rst_done"},  {31'd0, bus.done}, 32'd0);
                check({tag, "_rst_raddr"}, {21'd0, bus.memReadAddr}, 32'd0);
                check({tag, "_rst_waddr"}, {21'd0, bus.memWriteAddr}, 32'd0);
                check({tag, "_rst_out"},   bus.memOut, 32'd0);
                check({tag, "_rst_pending"}, expQ.size(), 32'd0);
                reset = 1'b0;
                aborted = 1'b1;
            end
        end while (!aborted && bus.done !== 1'b1 && k < expDone + 8);
        if (!aborted) begin
            check({tag, "_done_cycle"}, k, expDone);
            check({tag, "_pending"}, expQ.size(), 32'd0);
            check({tag, "_writes"}, writesSeen, expWrites);
        end
    endtask

    initial begin
        reset = 1'b1;
        tbWe = 1'b0; tbWAddr = 11'd0; tbWData = 32'd0;
        bus.start = 1'b0; bus.mode = 2'd0; bus.xAddr = 11'd0; bus.yAddr = 11'd0;
        bus.L = 16'd0; bus.setVal = 32'd0; bus.shift = 5'd0;
        repeat (3) @(negedge clk);
        check("reset_we",    {31'd0, bus.memWriteEn}, 32'd0);
        check("reset_busy",  {31'd0, bus.busy}, 32'd0);
        check("reset_done",  {31'd0, bus.done}, 32'd0);
        check("reset_raddr", {21'd0, bus.memReadAddr}, 32'd0);
        check("reset_waddr", {21'd0, bus.memWriteAddr}, 32'd0);
        check("reset_out",   bus.memOut, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: plain COPY 16 -> 1024
        for (int i = 0; i < 10; i++) poke(11'(16 + i), 32'(i + 1));
        for (int i = 0; i < 10; i++) pushExp(11'(1024 + i), 32'(i + 1), 1'b1);
        runOp("copy", 2'd0, 11'd16, 11'd1024, 16'd10, 32'd0, 5'd0, 12, 10, 0, 0);
        for (int i = 0; i < 10; i++) check("copy_mem", mem[1024 + i], 32'(i + 1));

        // 2: SET fill with guard words either side
        poke(11'd199, 32'h1111_1111);
        poke(11'd240, 32'h2222_2222);
        for (int i = 0; i < 40; i++) pushExp(11'(200 + i), 32'hDEAD_BEEF, 1'b1);
        runOp("set", 2'd1, 11'd0, 11'd200, 16'd40, 32'hDEAD_BEEF, 5'd0, 41, 40, 0, 0);
        check("set_guard_lo", mem[199], 32'h1111_1111);
        check("set_guard_hi", mem[240], 32'h2222_2222);
        check("set_first", mem[200], 32'hDEAD_BEEF);
        check("set_last", mem[239], 32'hDEAD_BEEF);

        // 3: arithmetic shift right by 3
        poke(11'd50, 32'h0000_0040); poke(11'd51, 32'hFFFF_FF80);
        poke(11'd52, 32'h7FFF_FFFF); poke(11'd53, 32'h8000_0000);
        pushExp(11'd60, 32'h0000_0008, 1'b1); pushExp(11'd61, 32'hFFFF_FFF0, 1'b1);
        pushExp(11'd62, 32'h0FFF_FFFF, 1'b1); pushExp(11'd63, 32'hF000_0000, 1'b1);
        runOp("shr", 2'd2, 11'd50, 11'd60, 16'd4, 32'd0, 5'd3, 6, 4, 0, 0);

        // reserved mode fills with zero regardless of setVal
        pushExp(11'd300, 32'd0, 1'b1); pushExp(11'd301, 32'd0, 1'b1);
        runOp("rsvd", 2'd3, 11'd0, 11'd300, 16'd2, 32'h1234_5678, 5'd0, 3, 2, 0, 0);

        // 4a: overlap with destination above source -> descending
        for (int i = 0; i < 8; i++) poke(11'(100 + i), 32'(i + 1));
        for (int i = 7; i >= 0; i--) pushExp(11'(102 + i), 32'(i + 1), 1'b1);
        runOp("ovl_desc", 2'd0, 11'd100, 11'd102, 16'd8, 32'd0, 5'd0, 10, 8, 0, 0);
        for (int i = 0; i < 8; i++) check("ovl_desc_mem", mem[102 + i], 32'(i + 1));

        // 4b: overlap with destination below source -> ascending
        for (int i = 0; i < 8; i++) poke(11'(102 + i), 32'(i + 1));
        for (int i = 0; i < 8; i++) pushExp(11'(100 + i), 32'(i + 1), 1'b1);
        runOp("ovl_asc", 2'd0, 11'd102, 11'd100, 16'd8, 32'd0, 5'd0, 10, 8, 0, 0);
        for (int i = 0; i < 8; i++) check("ovl_asc_mem", mem[100 + i], 32'(i + 1));

        // gap equal to L is not an overlap -> ascending
        for (int i = 0; i < 4; i++) poke(11'(400 + i), 32'(8'h51 + i));
        for (int i = 0; i < 4; i++) pushExp(11'(404 + i), 32'(8'h51 + i), 1'b1);
        runOp("gap_eq_len", 2'd0, 11'd400, 11'd404, 16'd4, 32'd0, 5'd0, 6, 4, 0, 0);

        // in-place copy rewrites the same words
        for (int i = 0; i < 3; i++) pushExp(11'(100 + i), 32'(i + 1), 1'b1);
        runOp("inplace", 2'd0, 11'd100, 11'd100, 16'd3, 32'd0, 5'd0, 5, 3, 0, 0);

        // 5a: L=0 completes immediately with no writes
        runOp("len0", 2'd0, 11'd16, 11'd500, 16'd0, 32'd0, 5'd0, 1, 0, 0, 0);

        // 5b: source wraps past the top of memory onto the destination
        poke(11'd2046, 32'h0000_00A1); poke(11'd2047, 32'h0000_00A2);
        poke(11'd0, 32'h0000_00A3);    poke(11'd1, 32'h0000_00A4);
        pushExp(11'd0, 32'h0000_00A1, 1'b1); pushExp(11'd1, 32'h0000_00A2, 1'b1);
        pushExp(11'd2, 32'd0, 1'b0);         pushExp(11'd3, 32'd0, 1'b0);
        runOp("wrap", 2'd0, 11'd2046, 11'd0, 16'd4, 32'd0, 5'd0, 6, 4, 0, 0);
        check("wrap_mem0", mem[0], 32'h0000_00A1);
        check("wrap_mem1", mem[1], 32'h0000_00A2);

        // 6a: start during RUN is ignored
        for (int i = 0; i < 10; i++) pushExp(11'(1024 + i), 32'(i + 1), 1'b1);
        runOp("start_ign", 2'd0, 11'd16, 11'd1024, 16'd10, 32'd0, 5'd0, 12, 10, 3, 0);

        // 6b: reset mid-run, then a fresh operation
        for (int i = 0; i < 4; i++) pushExp(11'(1300 + i), 32'(i + 1), 1'b1);
        runOp("mid_rst", 2'd0, 11'd16, 11'd1300, 16'd10, 32'd0, 5'd0, 12, 10, 0, 5);
        for (int i = 0; i < 10; i++) pushExp(11'(1300 + i), 32'(i + 1), 1'b1);
        runOp("after_rst", 2'd0, 11'd16, 11'd1300, 16'd10, 32'd0, 5'd0, 12, 10, 0, 0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
